// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester (fetch / load-store) arbiter for one single-port memory
//
// Purpose:
//   Picks between instruction fetch (IF) and load/store (LS) for a single
//   unified memory port, keeps track of the one outstanding transaction and
//   steers the memory response back to whoever issued it. LS normally wins;
//   after MAX_STARVE consecutive LS grants taken while IF was waiting, IF is
//   granted once.
//
// Ports:
//   clk, rst                      clock (rising edge), synchronous active-low reset
//   if_req/if_addr                fetch request and address
//   if_gnt/if_rvalid/if_rdata     fetch accept pulse, response pulse, data
//   ls_req/ls_we/ls_addr/
//   ls_wdata/ls_func3             load/store request and fields
//   ls_gnt/ls_rvalid/ls_rdata     load/store accept pulse, response pulse, data
//   mem_en/mem_we/mem_addr/
//   mem_wdata/mem_func3           memory request side
//   mem_ready                     memory accepts the request this cycle
//   mem_rvalid/mem_rdata          memory response (read data or write ack)

module mem_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_STARVE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic [DATA_WIDTH-1:0] ls_wdata,
    input  logic [2:0]            ls_func3,
    output logic                  ls_gnt,
    output logic                  ls_rvalid,
    output logic [DATA_WIDTH-1:0] ls_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [2:0]            mem_func3,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int             SW         = $clog2(MAX_STARVE + 1);
    localparam logic [SW-1:0]  STARVE_MAX = SW'(MAX_STARVE);
    localparam logic           OWN_IF     = 1'b0;
    localparam logic           OWN_LS     = 1'b1;
    localparam logic [2:0]     FUNC3_WORD = 3'b010;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic [SW-1:0] starve_q, starve_d;

    logic idle;
    logic sel_ls;
    logic sel_if;
    logic accept;
    logic rsp;

    // Selection and memory-side drive. Everything is gated by rst so that the
    // block is silent for the whole time reset is held, not just after it.
    always_comb begin
        idle      = (state_q == S_IDLE);
        // LS yields only when IF is waiting and has already been passed over
        // MAX_STARVE times in a row.
        sel_ls    = ls_req && !(if_req && (starve_q == STARVE_MAX));
        sel_if    = !sel_ls && if_req;
        mem_en    = rst && idle && (sel_ls || sel_if);
        accept    = mem_en && mem_ready;
        // A response only counts while a transaction is outstanding; stray or
        // late responses seen in IDLE are dropped.
        rsp       = rst && !idle && mem_rvalid;

        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_func3 = 3'b000;
        if (mem_en) begin
            if (sel_ls) begin
                mem_we    = ls_we;
                mem_addr  = ls_addr;
                mem_wdata = ls_wdata;
                mem_func3 = ls_func3;
            end else begin
                mem_addr  = if_addr;
                mem_func3 = FUNC3_WORD;
            end
        end

        ls_gnt    = accept && sel_ls;
        if_gnt    = accept && sel_if;
        ls_rvalid = rsp && (owner_q == OWN_LS);
        if_rvalid = rsp && (owner_q == OWN_IF);
        if_rdata  = rst ? mem_rdata : '0;
        ls_rdata  = rst ? mem_rdata : '0;
    end

    // Next-state: ownership and the starvation count only move on an accept.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        starve_d = starve_q;
        if (accept) begin
            state_d = S_BUSY;
            owner_d = sel_ls ? OWN_LS : OWN_IF;
            if (sel_ls && if_req) begin
                starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 1'b1;
            end else begin
                starve_d = '0;
            end
        end else if (rsp) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            owner_q  <= OWN_IF;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port unified memory between two requesters: instruction fetch (IF) and load/store (LS). It arbitrates requests, drives the memory port, tracks the single outstanding transaction and routes the response back to its owner. LS has priority by default. A starvation counter forces an IF grant after MAX_STARVE consecutive LS wins. It sits between the PC/fetch logic and the execute stage's data access on one side, and the memory on the other.

Parameters:
DATA_WIDTH, 32, width of data and read data
ADDR_WIDTH, 32, width of addresses
MAX_STARVE, 4, consecutive LS grants while IF waits before IF is forced (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-low
if_req  in  1  fetch request, held until if_gnt
if_addr  in  ADDR_WIDTH  fetch address (PC)
if_gnt  out  1  fetch accepted by memory (1-cycle pulse)
if_rvalid  out  1  fetch data valid (1-cycle pulse)
if_rdata  out  DATA_WIDTH  fetched instruction
ls_req  in  1  load/store request, held until ls_gnt
ls_we  in  1  1=store, 0=load
ls_addr  in  ADDR_WIDTH  data address (ALU result)
ls_wdata  in  DATA_WIDTH  store data
ls_func3  in  3  access size/sign (RV32 funct3)
ls_gnt  out  1  LS accepted by memory (1-cycle pulse)
ls_rvalid  out  1  load data valid / store ack (1-cycle pulse)
ls_rdata  out  DATA_WIDTH  load data (don't-care for stores)
mem_en  out  1  memory request valid
mem_we  out  1  memory write enable
mem_addr  out  ADDR_WIDTH  memory address
mem_wdata  out  DATA_WIDTH  memory write data
mem_func3  out  3  access size to memory
mem_ready  in  1  memory accepts request this cycle
mem_rvalid  in  1  memory response valid (read data or write ack)
mem_rdata  in  DATA_WIDTH  memory read data

Behaviour:
- Reset: rst sampled low at a rising edge -> state IDLE, owner=IF, starve_cnt=0. While rst is low, mem_en, mem_we, if_gnt, ls_gnt, if_rvalid and ls_rvalid are all 0. Data/address outputs are 0.
- FSM has two states, IDLE and BUSY. At most one transaction is outstanding.
- IDLE selection:
  - LS wins if ls_req=1 and NOT (if_req=1 and starve_cnt==MAX_STARVE).
  - Otherwise IF wins if if_req=1.
  - With no request, mem_en=0 and no state change.
- IDLE drive, combinational from the selection: mem_en=1.
  - LS selected: mem_we=ls_we, mem_addr=ls_addr, mem_wdata=ls_wdata, mem_func3=ls_func3.
  - IF selected: mem_we=0, mem_addr=if_addr, mem_wdata=0, mem_func3=3'b010.
- Accept: mem_en & mem_ready in IDLE -> the winner's gnt=1 that cycle; owner<=winner; next state BUSY. With mem_ready=0 there is no gnt and the selection is re-evaluated next cycle; a newly arrived LS may pre-empt a pending IF.
- BUSY:
  - mem_en=0, and mem_ready is ignored.
  - On mem_rvalid=1: owner's rvalid=1 and owner's rdata=mem_rdata (combinational pass-through); next state IDLE.
  - Non-owner rvalid stays 0. Both rdata outputs show mem_rdata at all times.
- Latency: gnt is issued in the accept cycle. rvalid appears in the same cycle as mem_rvalid. The earliest next accept is the cycle after rvalid (minimum 2 cycles per transaction).
- Starvation counter (saturating 0..MAX_STARVE), updated only on accept:
  - LS accepted while if_req=1 -> starve_cnt+1, saturating.
  - IF accepted -> 0.
  - LS accepted while if_req=0 -> 0.
- mem_rvalid in IDLE, including a late response after a mid-transaction reset, is ignored. No rvalid is generated.
- Reset mid-BUSY aborts tracking. The requester must reissue.
- A requester dropping req before gnt is permitted; the selection simply changes. Fields must be stable while req=1 and gnt=0.

Test Plan:
1. Reset: drive rst=0 for 2 cycles with if_req=ls_req=1 -> no gnt, mem_en=0. After rst=1 with mem_ready=1, the first cycle gives ls_gnt=1, mem_addr=ls_addr.
2. Single fetch: if_req=1, if_addr=0x00000004, mem_ready=1, mem_rvalid 2 cycles later with rdata=0x00500093 -> if_gnt in cycle 0, mem_func3=3'b010, mem_we=0, if_rvalid=1 with if_rdata=0x00500093 in cycle 2, ls_rvalid=0.
3. Store: ls_req=1, ls_we=1, ls_addr=0x100, ls_wdata=0xDEADBEEF, ls_func3=3'b000 -> mem_we=1 and mem fields match. The ack arrives on ls_rvalid.
4. Starvation, MAX_STARVE=4: hold if_req=1 and ls_req=1 continuously with an immediate response each transaction -> grant order LS,LS,LS,LS,IF,LS...; starve_cnt returns to 0 after the IF grant.
5. Backpressure: mem_ready=0 for 3 cycles with if_req=1, then ls_req=1 arrives in cycle 2 and mem_ready=1 in cycle 3 -> no gnt in cycles 0-2, ls_gnt in cycle 3, mem_en=1 throughout.
6. Reset mid-BUSY: LS load granted, rst=0 for 1 cycle, then mem_rvalid=1 arrives in IDLE -> ls_rvalid=0, if_rvalid=0, state IDLE, the next request is served normally.
